// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Covers op encodings, FSM states, the iteration count and the divide-by-zero quotient.
package muldiv_seq_pkg;

  localparam int unsigned ITER      = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_DIV   = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULTU = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Single-iteration datapath for the sequential multiply/divide unit.
// Performs either one restoring-division step or one shift-add multiply step on the 64-bit accumulator.
module muldiv_core (
  input  logic        is_mul,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] trial;
  logic [32:0] sum;

  // Division: acc = {remainder, dividend/quotient}; the shifted remainder needs 33 bits.
  // Multiply: acc = {partial product, multiplier}; the product shifts right into the low half.
  always_comb begin
    trial = acc_i[63:31] - {1'b0, opnd_i};
    sum   = {1'b0, acc_i[63:32]} + {1'b0, opnd_i};
    if (is_mul) begin
      acc_o = acc_i[0] ? {sum, acc_i[31:1]} : {1'b0, acc_i[63:1]};
    end else begin
      acc_o = trial[32] ? {acc_i[62:0], 1'b0} : {trial[31:0], acc_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit (div, divu, multu) with a hi/lo result write strobe.
// Uses a 32-cycle iterative core, a sign fixup stage, and a one-cycle done pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] rs_q, rs_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div0_q, div0_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        in_div0;
  logic [63:0] acc_step;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign accept  = (state_q == S_IDLE) && start && !cancel && (op_e'(op) != OP_RSVD);
  assign in_div0 = (rt_data == '0) && (op_e'(op) != OP_MULTU);

  muldiv_core u_core (
    .is_mul (op_q == OP_MULTU),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = in_div0 ? S_FIXUP : S_CALC;
      S_CALC:  if (cnt_q == 5'(ITER - 1)) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel) state_d = S_IDLE;
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE) && !cancel;
    hilo_we = done;
  end

  // Signed div works on magnitudes; the result signs are restored here.
  always_comb begin
    fix_hi = acc_q[63:32];
    fix_lo = acc_q[31:0];
    if (div0_q) begin
      fix_hi = rs_q;
      fix_lo = DIV0_QUOT;
    end else if (op_q == OP_DIV) begin
      fix_hi = r_neg_q ? -acc_q[63:32] : acc_q[63:32];
      fix_lo = q_neg_q ? -acc_q[31:0]  : acc_q[31:0];
    end
  end

  always_comb begin
    op_d    = op_q;
    opnd_d  = opnd_q;
    rs_d    = rs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    div0_d  = div0_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (accept) begin
      op_d    = op_e'(op);
      rs_d    = rs_data;
      cnt_d   = '0;
      div0_d  = in_div0;
      q_neg_d = rs_data[31] ^ rt_data[31];
      r_neg_d = rs_data[31];
      unique case (op_e'(op))
        OP_DIV: begin
          opnd_d = abs32(rt_data);
          acc_d  = {32'h0, abs32(rs_data)};
        end
        OP_DIVU: begin
          opnd_d = rt_data;
          acc_d  = {32'h0, rs_data};
        end
        default: begin
          opnd_d = rs_data;
          acc_d  = {32'h0, rt_data};
        end
      endcase
    end else if (!cancel && state_q == S_CALC) begin
      acc_d = acc_step;
      cnt_d = cnt_q + 5'd1;
    end else if (!cancel && state_q == S_FIXUP) begin
      hi_d = fix_hi;
      lo_d = fix_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_DIV;
      opnd_q  <= '0;
      rs_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      div0_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      rs_q    <= rs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      div0_q  <= div0_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a driver queues expected hi/lo/latency from an arithmetic model,
// and a monitor compares them whenever done pulses.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned busy_run = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .cancel  (cancel),
    .busy    (busy),
    .done    (done),
    .hilo_we (hilo_we),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero
  // and the remainder follows the dividend, matching MIPS div semantics.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint          sa, sbv, q, r;
    longint unsigned p;
    if (o != 2'd2 && b == 32'h0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.lat = 2;
    end else begin
      e.lat = 34;
      case (o)
        2'd0: begin
          sa   = longint'($signed(a));
          sbv  = longint'($signed(b));
          q    = sa / sbv;
          r    = sa % sbv;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
        2'd1: begin
          e.lo = a / b;
          e.hi = a % b;
        end
        default: begin
          p    = {32'h0, a} * {32'h0, b};
          e.hi = p[63:32];
          e.lo = p[31:0];
        end
      endcase
    end
    return e;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %b after 200 cycles, required 0", busy);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    wait_idle();
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    if (push) begin
      e = model(o, a, b);
      exp_q.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  // Monitor: counts busy cycles of the current operation and checks each done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if (done) begin
          chk("hilo_we_eq_done", 64'(hilo_we), 64'(1'b1));
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done with hi=%h lo=%h, required no done", hi_out, lo_out);
          end else begin
            e = exp_q.pop_front();
            chk("hi", 64'(hi_out), 64'(e.hi));
            chk("lo", 64'(lo_out), 64'(e.lo));
            chk("latency", 64'(busy_run), 64'(e.lat));
          end
        end
        if (!busy) busy_run = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0; cancel = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hilo_we", 64'(hilo_we), 64'(0));
    chk("reset_hilo", {hi_out, lo_out}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue(2'd1, 32'd100, 32'd7, 1);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 1);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(2'd1, 32'h1234_5678, 32'h0, 1);
    issue(2'd0, 32'h8765_4321, 32'h0, 1);
    issue(2'd0, 32'd7, 32'hFFFF_FFFE, 1);

    issue(2'd3, 32'd5, 32'd6, 0);
    chk("rsvd_ignored", 64'(busy), 64'(0));

    // Cancel mid-CALC: no write, hi/lo hold the previous result.
    issue(2'd1, 32'hDEAD_BEEF, 32'd3, 0);
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'(0));
    chk("cancel_hilo_held", {hi_out, lo_out}, {last_hi, last_lo});
    repeat (40) @(posedge clk);
    #1;

    // Cancel together with start in IDLE: nothing accepted.
    op = 2'd1; rs_data = 32'd50; rt_data = 32'd5; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    chk("cancel_beats_start", 64'(busy), 64'(0));

    // Start while busy must not disturb the running operation.
    issue(2'd2, 32'h0001_0003, 32'h0002_0005, 1);
    repeat (5) @(posedge clk);
    #1 op = 2'd1; rs_data = 32'd1; rt_data = 32'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1 chk("busy_start_ignored", 64'(busy), 64'(0));

    // Asynchronous reset mid-operation.
    issue(2'd1, 32'hCAFE_F00D, 32'd11, 0);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'({done, hilo_we}), 64'(0));
    chk("midrst_hilo", {hi_out, lo_out}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    issue(2'd1, 32'd9, 32'd3, 1);

    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) ra = ra | 32'h8000_0000;
      if (ro == 2'd3) begin
        issue(ro, ra, rb, 0);
        chk("rand_rsvd_ignored", 64'(busy), 64'(0));
      end else begin
        issue(ro, ra, rb, 1);
      end
    end

    wait_idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 op  input  2  operation: 00 div (signed), 01 divu, 10 multu, 11 reserved.
REQ-005 rs_data  input  32  dividend / multiplicand (register rs value).
REQ-006 rt_data  input  32  divisor / multiplier (register rt value).
REQ-007 cancel  input  1  flush from exception/eret; aborts the current operation.
REQ-008 busy  output  1  high whenever state != IDLE; drives the PC-enable stall.
REQ-009 done  output  1  one-cycle pulse when a result is valid.
REQ-010 hilo_we  output  1  write strobe to the hi and lo registers; equals done.
REQ-011 hi_out  output  32  remainder (div/divu) or product[63:32] (multu).
REQ-012 lo_out  output  32  quotient (div/divu) or product[31:0] (multu).

Function
REQ-013 States SHALL be IDLE, CALC, FIXUP and DONE.
REQ-014 Start handling:
- In IDLE, start=1 with op!=11 and cancel=0 latches op, rs_data and rt_data.
- The block then enters CALC with the iteration counter at 0.
REQ-015 op=11 SHALL be ignored; the block stays in IDLE.
REQ-016 start while busy=1 SHALL be ignored; latched operands and op are unchanged.
REQ-017 CALC SHALL run exactly 32 cycles, one bit per cycle, counter 0..31; at 31 the next state is FIXUP.
REQ-018 Division core: radix-2 restoring division on unsigned magnitudes.
- For div, operand magnitudes are taken at latch time.
REQ-019 Multiply core: shift-add, 64-bit accumulator; multu only.
REQ-020 FIXUP for div:
- Quotient negated when sign(rs) XOR sign(rt) is 1.
- Remainder takes the sign of rs.
- Other ops pass through unchanged.
REQ-021 Signed overflow: div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000 (two's complement wrap, no trap).
REQ-022 Divide by zero (rt=0, div or divu): CALC SHALL be skipped, FIXUP entered next cycle, result lo=0xFFFFFFFF, hi=rs_data.
REQ-023 DONE lasts one cycle with done=hilo_we=1; hi_out/lo_out are valid during that cycle and held until the next accepted start.
- Next state is IDLE.
REQ-024 Latency from the accepting edge to the done cycle:
- normal operation: 34 cycles (32 CALC + FIXUP + DONE);
- divide by zero: 2 cycles.
REQ-025 cancel=1 in any state SHALL force IDLE on the next edge.
- done and hilo_we are 0 in that cycle; hi_out/lo_out are not updated.
REQ-026 cancel and start asserted together in IDLE: cancel wins, nothing is latched.
REQ-027 A start on the cycle the block returns to IDLE SHALL be accepted, giving back-to-back operation.

Reset
REQ-028 rst=1 SHALL immediately clear:
- state to IDLE;
- counter, accumulator and latched operands;
- busy, done, hilo_we, hi_out and lo_out to 0.
REQ-029 Reset mid-operation SHALL abort without a write; the first start after release behaves as from power-up.

Structure
REQ-030 A shared package SHALL hold the op encodings, the state enum, the ITER=32 constant and the div-by-zero quotient constant 0xFFFFFFFF.
REQ-031 One sub-module SHALL be used: muldiv_core, holding the per-cycle shift/subtract/add datapath.
- The FSM, counter, sign fixup and output registers stay in muldiv_seq.

Verification
REQ-032 divu rs=100, rt=7 -> done 34 cycles after start, lo=14, hi=2, busy high for 34 cycles.
REQ-033 div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 multu rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at cycle 34.
REQ-035 divu rs=0x12345678, rt=0 -> done at cycle 2, lo=0xFFFFFFFF, hi=0x12345678.
REQ-036 cancel at CALC cycle 10 -> busy low next cycle, no hilo_we, hi/lo keep prior values; second start during busy produces no extra done.
REQ-037 rst asserted mid-CALC -> all outputs 0 asynchronously; a following divu 9/3 -> lo=3, hi=0.
